// File: rtl/i2c_tmp101_responder_if.sv
// I2C bus signals as seen at the responder pins: raw SCL/SDA levels in and
// the open-drain pull-down request out.
interface i2c_tmp101_responder_if;
  logic scl;
  logic sda_in;
  logic sda_pull;

  modport slave (
    input  scl,
    input  sda_in,
    output sda_pull
  );

  modport master (
    output scl,
    output sda_in,
    input  sda_pull
  );
endinterface

// File: rtl/i2c_tmp101_responder.sv
// TMP101-style I2C target: pointer/config writes and snapshotted temperature reads.
// The bus is oversampled on clk_sys; all protocol decisions use synchronized SCL edges.
//
// state    | meaning
// IDLE     | bus free, waiting for START
// ADDR     | shifting in the address byte
// ADDR_ACK | pulling SDA low to acknowledge our address
// WR_BYTE  | shifting in a pointer or data byte
// WR_ACK   | acknowledging a written byte
// RD_BYTE  | driving a read byte MSB first
// RD_ACK   | SDA released, sampling the initiator ACK/NACK
// IGNORE   | not addressed or read ended, waiting for START/STOP
module i2c_tmp101_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'b1001000,
  parameter logic [7:0] CFG_RESET = 8'h00
) (
  input  logic                         clk_sys,
  input  logic                         rst,
  i2c_tmp101_responder_if.slave        bus,
  input  logic [11:0]                  temperature,
  output logic [7:0]                   config_reg,
  output logic [1:0]                   pointer_reg,
  output logic                         busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  tx_q, tx_d;
  logic [11:0] snap_q, snap_d;
  logic [7:0]  config_q, config_d;
  logic [1:0]  pointer_q, pointer_d;
  logic        pull_q, pull_d;
  logic        first_q, first_d;
  logic        phase_q, phase_d;
  logic        ack_q, ack_d;

  logic [2:0]  scl_sync, sda_sync;
  logic        scl_rise, scl_fall, start_det, stop_det;
  logic [7:0]  rd_first, rd_next;

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      scl_sync <= 3'b111;
      sda_sync <= 3'b111;
    end else begin
      scl_sync <= {scl_sync[1:0], bus.scl};
      sda_sync <= {sda_sync[1:0], bus.sda_in};
    end
  end

  assign scl_rise  =  scl_sync[1] & ~scl_sync[2];
  assign scl_fall  = ~scl_sync[1] &  scl_sync[2];
  assign start_det =  scl_sync[1] &  sda_sync[2] & ~sda_sync[1];
  assign stop_det  =  scl_sync[1] & ~sda_sync[2] &  sda_sync[1];

  // Pointer 00 alternates MSB/LSB halves of the reading; phase 0 is the MSB byte.
  function automatic logic [7:0] read_byte(input logic [1:0]  ptr,
                                           input logic        phase,
                                           input logic [11:0] snap,
                                           input logic [7:0]  cfg);
    logic [7:0] b;
    case (ptr)
      2'b00:   b = phase ? {snap[3:0], 4'b0000} : snap[11:4];
      2'b01:   b = cfg;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  assign rd_first = read_byte(pointer_q, 1'b0, temperature, config_q);
  assign rd_next  = read_byte(pointer_q, ~phase_q, snap_q, config_q);

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      shift_q   <= 8'h00;
      tx_q      <= 8'h00;
      snap_q    <= 12'h000;
      config_q  <= CFG_RESET;
      pointer_q <= 2'b00;
      pull_q    <= 1'b0;
      first_q   <= 1'b0;
      phase_q   <= 1'b0;
      ack_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      snap_q    <= snap_d;
      config_q  <= config_d;
      pointer_q <= pointer_d;
      pull_q    <= pull_d;
      first_q   <= first_d;
      phase_q   <= phase_d;
      ack_q     <= ack_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    snap_d    = snap_q;
    config_d  = config_q;
    pointer_d = pointer_q;
    pull_d    = pull_q;
    first_d   = first_q;
    phase_d   = phase_q;
    ack_d     = ack_q;

    if (stop_det) begin
      state_d = IDLE;
      cnt_d   = 4'd0;
      pull_d  = 1'b0;
    end else if (start_det) begin
      state_d = ADDR;
      cnt_d   = 4'd0;
      pull_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: pull_d = 1'b0;

        ADDR: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_sync[1]};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            if (shift_q[7:1] == DEV_ADDR) begin
              state_d = ADDR_ACK;
              pull_d  = 1'b1;
            end else begin
              state_d = IGNORE;
            end
          end
        end

        ADDR_ACK: begin
          if (scl_fall) begin
            cnt_d = 4'd0;
            if (shift_q[0]) begin
              state_d = RD_BYTE;
              snap_d  = temperature;
              phase_d = 1'b0;
              tx_d    = rd_first;
              pull_d  = ~rd_first[7];
            end else begin
              state_d = WR_BYTE;
              first_d = 1'b1;
              pull_d  = 1'b0;
            end
          end
        end

        WR_BYTE: begin
          if (scl_rise) begin
            shift_d = {shift_q[6:0], sda_sync[1]};
            cnt_d   = cnt_q + 4'd1;
          end else if (scl_fall && cnt_q == 4'd8) begin
            // Commit only on a complete byte, so an aborted byte never lands.
            if (first_q)
              pointer_d = shift_q[1:0];
            else if (pointer_q == 2'b01)
              config_d = shift_q;
            first_d = 1'b0;
            state_d = WR_ACK;
            pull_d  = 1'b1;
          end
        end

        WR_ACK: begin
          if (scl_fall) begin
            state_d = WR_BYTE;
            cnt_d   = 4'd0;
            pull_d  = 1'b0;
          end
        end

        RD_BYTE: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 4'd1;
          end else if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              state_d = RD_ACK;
              pull_d  = 1'b0;
              ack_d   = 1'b0;
            end else begin
              tx_d   = {tx_q[6:0], 1'b0};
              pull_d = ~tx_q[6];
            end
          end
        end

        RD_ACK: begin
          pull_d = 1'b0;
          if (scl_rise) begin
            if (sda_sync[1])
              state_d = IGNORE;
            else
              ack_d = 1'b1;
          end else if (scl_fall && ack_q) begin
            state_d = RD_BYTE;
            cnt_d   = 4'd0;
            phase_d = ~phase_q;
            tx_d    = rd_next;
            pull_d  = ~rd_next[7];
          end
        end

        IGNORE: pull_d = 1'b0;

        default: begin
          state_d = IDLE;
          pull_d  = 1'b0;
        end
      endcase
    end
  end

  assign bus.sda_pull = pull_q;
  assign config_reg   = config_q;
  assign pointer_reg  = pointer_q;
  assign busy         = (state_q == ADDR_ACK) || (state_q == WR_BYTE) ||
                        (state_q == WR_ACK)   || (state_q == RD_BYTE) ||
                        (state_q == RD_ACK);

endmodule

// File: tb/tb_i2c_tmp101_responder.sv
// Bench for i2c_tmp101_responder: a bit-banged I2C initiator drives directed
// transactions; expected and observed values meet in queues checked by a monitor.
module tb_i2c_tmp101_responder;

  localparam logic [7:0] CFG_RST = 8'hA5;

  typedef struct {
    string       name;
    logic [31:0] val;
  } item_t;

  logic        clk_sys = 1'b0;
  logic        rst     = 1'b1;
  logic        tb_scl  = 1'b1;
  logic        tb_sda  = 1'b1;
  logic [11:0] temperature = 12'h000;
  logic [7:0]  config_reg;
  logic [1:0]  pointer_reg;
  logic        busy;

  item_t exp_q[$];
  item_t obs_q[$];
  int    tests  = 0;
  int    failed = 0;

  logic win = 1'b0;
  int   pull_hi = 0;
  int   busy_hi = 0;

  i2c_tmp101_responder_if bus();
  assign bus.scl    = tb_scl;
  assign bus.sda_in = tb_sda & ~bus.sda_pull;

  i2c_tmp101_responder #(
    .DEV_ADDR  (7'b1001000),
    .CFG_RESET (CFG_RST)
  ) dut (
    .clk_sys     (clk_sys),
    .rst         (rst),
    .bus         (bus.slave),
    .temperature (temperature),
    .config_reg  (config_reg),
    .pointer_reg (pointer_reg),
    .busy        (busy)
  );

  always #5 clk_sys = ~clk_sys;

  always @(posedge clk_sys) begin
    if (win) begin
      if (bus.sda_pull) pull_hi++;
      if (busy) busy_hi++;
    end
  end

  // Monitor: pair each observation with the oldest expectation.
  always @(negedge clk_sys) begin
    if (obs_q.size() > 0) begin
      item_t o, e;
      o = obs_q.pop_front();
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL %s: got %0h, no expected value queued", o.name, o.val);
      end else begin
        e = exp_q.pop_front();
        if (o.val !== e.val || o.name != e.name) begin
          failed++;
          $display("FAIL %s: got %0h (%s), expected %0h", e.name, o.val, o.name, e.val);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string n, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    exp_q.push_back(it);
  endtask

  task automatic observe(input string n, input logic [31:0] v);
    item_t it;
    it.name = n;
    it.val  = v;
    obs_q.push_back(it);
  endtask

  task automatic q_wait();
    #50;
  endtask

  task automatic i2c_start();
    tb_sda = 1'b1; q_wait();
    tb_scl = 1'b1; q_wait();
    tb_sda = 1'b0; q_wait();
    tb_scl = 1'b0; q_wait();
  endtask

  task automatic i2c_stop();
    tb_sda = 1'b0; q_wait();
    tb_scl = 1'b1; q_wait();
    tb_sda = 1'b1; q_wait();
    q_wait();
  endtask

  task automatic write_bit(input logic b);
    tb_sda = b;    q_wait();
    tb_scl = 1'b1; q_wait(); q_wait();
    tb_scl = 1'b0; q_wait();
  endtask

  task automatic read_bit(output logic b);
    tb_sda = 1'b1; q_wait();
    tb_scl = 1'b1; q_wait();
    b = bus.sda_in; q_wait();
    tb_scl = 1'b0; q_wait();
  endtask

  task automatic write_byte(input string n, input logic [7:0] b, input logic exp_ack);
    logic s;
    expect_v(n, {31'd0, exp_ack});
    for (int i = 7; i >= 0; i--) write_bit(b[i]);
    read_bit(s);
    observe(n, {31'd0, ~s});
  endtask

  task automatic read_byte(input string n, input logic [7:0] exp_b, input logic nack);
    logic [7:0] b;
    logic       s;
    expect_v(n, {24'd0, exp_b});
    for (int i = 7; i >= 0; i--) begin
      read_bit(s);
      b[i] = s;
    end
    write_bit(nack);
    observe(n, {24'd0, b});
  endtask

  task automatic check_reg(input string n, input logic [31:0] exp_v, input logic [31:0] act_v);
    expect_v(n, exp_v);
    observe(n, act_v);
  endtask

  initial begin
    repeat (3) @(posedge clk_sys);
    @(negedge clk_sys) rst = 1'b0;
    repeat (2) @(negedge clk_sys);

    check_reg("rst_config",  32'(CFG_RST), 32'(config_reg));
    check_reg("rst_pointer", 32'd0, 32'(pointer_reg));
    check_reg("rst_busy",    32'd0, 32'(busy));
    check_reg("rst_pull",    32'd0, 32'(bus.sda_pull));

    // Pointer then config write.
    i2c_start();
    write_byte("w1_addr_ack", 8'h90, 1'b1);
    check_reg("w1_busy", 32'd1, 32'(busy));
    write_byte("w1_ptr_ack", 8'h01, 1'b1);
    write_byte("w1_data_ack", 8'h60, 1'b1);
    check_reg("w1_pointer", 32'd1, 32'(pointer_reg));
    check_reg("w1_config", 32'h60, 32'(config_reg));
    i2c_stop();
    check_reg("w1_busy_after_stop", 32'd0, 32'(busy));

    // Config read back via repeated START.
    i2c_start();
    write_byte("r1_addr_ack", 8'h90, 1'b1);
    write_byte("r1_ptr_ack", 8'h01, 1'b1);
    i2c_start();
    write_byte("r1_raddr_ack", 8'h91, 1'b1);
    read_byte("r1_cfg", 8'h60, 1'b1);
    check_reg("r1_pull_after_nack", 32'd0, 32'(bus.sda_pull));
    i2c_stop();

    // Temperature read.
    temperature = 12'h190;
    i2c_start();
    write_byte("t1_addr_ack", 8'h90, 1'b1);
    write_byte("t1_ptr_ack", 8'h00, 1'b1);
    i2c_start();
    write_byte("t1_raddr_ack", 8'h91, 1'b1);
    read_byte("t1_msb", 8'h19, 1'b0);
    read_byte("t1_lsb", 8'h00, 1'b1);
    check_reg("t1_pull_after_nack", 32'd0, 32'(bus.sda_pull));
    i2c_stop();
    check_reg("t1_pointer", 32'd0, 32'(pointer_reg));

    // Temperature changes after the snapshot; bytes must not follow it.
    i2c_start();
    write_byte("t2_raddr_ack", 8'h91, 1'b1);
    temperature = 12'hFF0;
    read_byte("t2_msb", 8'h19, 1'b0);
    read_byte("t2_lsb", 8'h00, 1'b0);
    read_byte("t2_msb_again", 8'h19, 1'b1);
    i2c_stop();

    // Address mismatch: never acknowledged, never busy.
    pull_hi = 0;
    busy_hi = 0;
    win = 1'b1;
    i2c_start();
    write_byte("m1_addr_nack", 8'h92, 1'b0);
    write_byte("m1_data_nack", 8'h55, 1'b0);
    i2c_stop();
    win = 1'b0;
    check_reg("m1_pull_cycles", 32'd0, 32'(pull_hi));
    check_reg("m1_busy_cycles", 32'd0, 32'(busy_hi));

    // Pointer 10: data byte discarded, reads return zero.
    i2c_start();
    write_byte("p2_addr_ack", 8'h90, 1'b1);
    write_byte("p2_ptr_ack", 8'h02, 1'b1);
    write_byte("p2_data_ack", 8'h55, 1'b1);
    i2c_start();
    write_byte("p2_raddr_ack", 8'h91, 1'b1);
    read_byte("p2_read", 8'h00, 1'b1);
    i2c_stop();
    check_reg("p2_config_kept", 32'h60, 32'(config_reg));
    check_reg("p2_pointer", 32'd2, 32'(pointer_reg));

    // Partial data byte aborted by STOP.
    i2c_start();
    write_byte("a1_addr_ack", 8'h90, 1'b1);
    write_byte("a1_ptr_ack", 8'h01, 1'b1);
    write_bit(1'b1); write_bit(1'b0); write_bit(1'b1); write_bit(1'b0);
    i2c_stop();
    check_reg("a1_config_kept", 32'h60, 32'(config_reg));
    check_reg("a1_busy", 32'd0, 32'(busy));
    check_reg("a1_pointer", 32'd1, 32'(pointer_reg));

    // Reset while acknowledging the address.
    begin
      logic seen;
      seen = 1'b0;
      i2c_start();
      for (int i = 7; i >= 0; i--) write_bit(i == 7 || i == 4);
      tb_sda = 1'b1;
      for (int k = 0; k < 40 && !seen; k++) begin
        @(negedge clk_sys);
        seen = bus.sda_pull;
      end
      check_reg("x1_pull_before_reset", 32'd1, 32'(seen));
      @(negedge clk_sys) rst = 1'b1;
      @(posedge clk_sys);
      #1;
      check_reg("x1_pull_after_reset", 32'd0, 32'(bus.sda_pull));
      check_reg("x1_config_after_reset", 32'(CFG_RST), 32'(config_reg));
      @(negedge clk_sys) rst = 1'b0;
      check_reg("x1_pointer_after_reset", 32'd0, 32'(pointer_reg));
      check_reg("x1_busy_after_reset", 32'd0, 32'(busy));
      tb_scl = 1'b1; q_wait();
      tb_scl = 1'b0; q_wait();
      i2c_stop();
    end

    // Block works normally after the reset.
    i2c_start();
    write_byte("y1_addr_ack", 8'h90, 1'b1);
    write_byte("y1_ptr_ack", 8'h01, 1'b1);
    write_byte("y1_data_ack", 8'h33, 1'b1);
    i2c_stop();
    check_reg("y1_config", 32'h33, 32'(config_reg));

    repeat (10) @(negedge clk_sys);
    if (exp_q.size() != 0 || obs_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected and %0d observed items left, required 0",
               exp_q.size(), obs_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/i2c_tmp101_responder.md
I2C_TMP101_RESPONDER -- requirements
Module: i2c_tmp101_responder

Interface
REQ-001 Parameter: DEV_ADDR, 7'b1001000, 7-bit I2C target address this block answers to.
REQ-002 Parameter: CFG_RESET, 8'h00, value loaded into ConfigReg at reset.
REQ-003 CLOCK  input  1  single system clock; all state changes on posedge; at least 16x faster than SCL.
REQ-004 Reset  input  1  synchronous, active-high reset; sampled on posedge CLOCK only.
REQ-005 SCL  input  1  raw bus clock from the initiator (asynchronous to CLOCK).
REQ-006 SDA_in  input  1  raw bus data level (asynchronous to CLOCK).
REQ-007 Temperature  input  12  sensor reading, two's complement, 0.0625 C/LSB.
REQ-008 SDA_pull  output  1  1 = drive SDA low (open-drain), 0 = release.
REQ-009 ConfigReg  output  8  configuration register, writable over the bus.
REQ-010 PointerReg  output  2  register pointer last written over the bus.
REQ-011 Busy  output  1  high from address match until STOP or next START.

Function
REQ-012 SCL and SDA_in shall each pass through a 2-flop synchronizer; a third flop gives the previous value for edge detection.
REQ-013 START = synced SDA falling while synced SCL high; STOP = synced SDA rising while synced SCL high.
REQ-014 Data bits shall be sampled on the synced SCL rising edge; SDA_pull shall change only on the synced SCL falling edge.
REQ-015 States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
REQ-016 IDLE: wait for START -> ADDR with bit counter = 0; SDA_pull = 0.
REQ-017 ADDR: shift 8 bits MSB first; after the 8th bit, if bits[7:1] == DEV_ADDR -> ADDR_ACK, else -> IGNORE.
REQ-018 ADDR_ACK: SDA_pull = 1 from the falling edge after bit 8 until the next falling edge; R/W bit 0 -> WR_BYTE, 1 -> RD_BYTE.
REQ-019 On entry to RD_BYTE from ADDR_ACK, Temperature shall be latched into a 12-bit snapshot; the read uses only the snapshot.
REQ-020 WR_BYTE: shift 8 bits; first byte after address -> PointerReg = byte[1:0]; second and later bytes -> ConfigReg = byte only when PointerReg == 2'b01, otherwise discarded; -> WR_ACK.
REQ-021 WR_ACK: ACK every written byte (SDA_pull = 1 for one SCL low/high period), then -> WR_BYTE.
REQ-022 RD_BYTE: output byte MSB first, SDA_pull = ~bit; bit 7 presented on the falling edge that ends the ACK.
REQ-023 Read data: PointerReg 00 -> byte 0 = snapshot[11:4], byte 1 = {snapshot[3:0], 4'b0000}, then alternating; 01 -> ConfigReg on every byte; 10/11 -> 8'h00.
REQ-024 RD_ACK: release SDA; sample the initiator bit on SCL rising edge: 0 (ACK) -> RD_BYTE with next byte; 1 (NACK) -> IGNORE.
REQ-025 IGNORE: SDA_pull = 0; wait for STOP or START.
REQ-026 STOP in any state -> IDLE, SDA_pull = 0 on the following posedge CLOCK.
REQ-027 START in any state (repeated start) -> ADDR with bit counter cleared; PointerReg and ConfigReg are kept.
REQ-028 Busy = 1 in ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK; 0 otherwise.
REQ-029 A partially received byte aborted by START or STOP shall not update PointerReg or ConfigReg.

Reset
REQ-030 On posedge CLOCK with Reset = 1: state = IDLE, SDA_pull = 0, Busy = 0, PointerReg = 2'b00, ConfigReg = CFG_RESET, bit counter = 0, shift register and snapshot = 0, synchronizer flops = 1 (bus idle).
REQ-031 Reset asserted mid-transaction shall abort it with no register update; after release the block waits for a new START.

Verification
REQ-032 Write 0x90, 0x01, 0x60 -> ACK on all three bytes, PointerReg = 01, ConfigReg = 8'h60 after the third ACK.
REQ-033 Temperature = 12'h190, write 0x90, 0x00, repeated START, read 0x91, initiator ACK then NACK -> bytes 8'h19, 8'h00; SDA released after the NACK.
REQ-034 Address 0x92 (mismatch) -> no ACK, SDA_pull stays 0, Busy stays 0 until STOP.
REQ-035 Temperature changes from 12'h190 to 12'hFF0 during a read -> bytes stay 8'h19, 8'h00 (snapshot used).
REQ-036 STOP after 4 bits of the ConfigReg data byte -> ConfigReg unchanged, state IDLE, Busy = 0.
REQ-037 Reset pulsed while SDA_pull = 1 during ADDR_ACK -> SDA_pull = 0 on the next posedge CLOCK, ConfigReg = CFG_RESET.
